// File: rtl/memory_access_if.sv
// Word-wide data-memory request/acknowledge bus with byte enables.
interface memory_access_if #(
  parameter int unsigned DATA_W = 32
);
  logic              req;
  logic              we;
  logic [DATA_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [3:0]        be;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, be, input ack, rdata);
  modport slave  (input req, we, addr, wdata, be, output ack, rdata);
endinterface

// File: rtl/memory_access.sv
// Memory-access stage: drives the data-memory bus, extends loads and holds the MEM/WB register.
// Optional macro MEM_MISALIGN_TRAP_EN suppresses misaligned accesses and flags them in MEM/WB.
module memory_access #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned REG_ADDR = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clk_en,
  input  logic                i_ex_mem_to_reg,
  input  logic                i_ex_reg_wr,
  input  logic                i_ex_mem_rd,
  input  logic                i_ex_mem_wr,
  input  logic                i_ex_result_src,
  input  logic [REG_ADDR-1:0] i_ex_reg_destination,
  input  logic [2:0]          i_ex_funct3,
  input  logic [DATA_W-1:0]   i_ex_alu_result,
  input  logic [DATA_W-1:0]   i_ex_data2,
  input  logic [DATA_W-1:0]   i_ex_pc_plus_4,
  memory_access_if.master     dmem,
  output logic                o_mem_stall,
  output logic                o_mem_misaligned,
  output logic                o_mem_mem_to_reg,
  output logic                o_mem_reg_wr,
  output logic                o_mem_result_src,
  output logic [REG_ADDR-1:0] o_mem_reg_destination,
  output logic [DATA_W-1:0]   o_mem_read_data,
  output logic [DATA_W-1:0]   o_mem_alu_result,
  output logic [DATA_W-1:0]   o_mem_pc_plus_4
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StHold = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] hold_q;
  logic              access, trap, legal, req, is_load;
  logic [1:0]        lane;
  logic [3:0]        be;
  logic [DATA_W-1:0] wdata, word, load_ext;
  logic [7:0]        lane_b;
  logic [15:0]       lane_h;

  assign access = i_ex_mem_rd | i_ex_mem_wr;
  assign lane   = i_ex_alu_result[1:0];

`ifdef MEM_MISALIGN_TRAP_EN
  logic half_acc, word_acc;
  // funct3 101 is only a halfword access for loads; as a store it is an illegal code.
  assign half_acc = (i_ex_funct3 == 3'b001) | ((i_ex_funct3 == 3'b101) & ~i_ex_mem_wr);
  assign word_acc = (i_ex_funct3 == 3'b010);
  assign trap     = access & ((half_acc & lane[0]) | (word_acc & (|lane)));
`else
  assign trap = 1'b0;
`endif

  assign legal   = access & ~trap;
  assign is_load = i_ex_mem_rd & ~i_ex_mem_wr & ~trap;

  // Gated by rst_n so a reset during WAIT drops the request immediately.
  assign req         = rst_n & (((state_q == StIdle) & legal) | (state_q == StWait));
  assign o_mem_stall = req & ~dmem.ack;

  always_comb begin
    be    = 4'b1111;
    wdata = i_ex_data2;
    if (i_ex_mem_wr) begin
      case (i_ex_funct3)
        3'b000: begin
          be    = 4'b0001 << lane;
          wdata = {4{i_ex_data2[7:0]}};
        end
        3'b001: begin
          be    = lane[1] ? 4'b1100 : 4'b0011;
          wdata = {2{i_ex_data2[15:0]}};
        end
        3'b010:  be = 4'b1111;
        default: be = 4'b0000;
      endcase
    end
  end

  assign dmem.req   = req;
  assign dmem.we    = req & i_ex_mem_wr;
  assign dmem.addr  = req ? {i_ex_alu_result[DATA_W-1:2], 2'b00} : '0;
  assign dmem.wdata = req ? wdata : '0;
  assign dmem.be    = req ? be : 4'b0000;

  // In HOLD the bus is idle, so the load word comes from the captured buffer.
  assign word   = (state_q == StHold) ? hold_q : dmem.rdata;
  assign lane_b = word[{lane, 3'b000} +: 8];
  assign lane_h = word[{lane[1], 4'b0000} +: 16];

  always_comb begin
    case (i_ex_funct3)
      3'b000:  load_ext = {{24{lane_b[7]}}, lane_b};
      3'b001:  load_ext = {{16{lane_h[15]}}, lane_h};
      3'b010:  load_ext = word;
      3'b100:  load_ext = {24'b0, lane_b};
      3'b101:  load_ext = {16'b0, lane_h};
      default: load_ext = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (legal) state_d = dmem.ack ? (clk_en ? StIdle : StHold) : StWait;
      StWait: if (dmem.ack) state_d = clk_en ? StIdle : StHold;
      StHold: if (clk_en) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      if (req && dmem.ack) hold_q <= dmem.rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_mem_misaligned      <= 1'b0;
      o_mem_mem_to_reg      <= 1'b0;
      o_mem_reg_wr          <= 1'b0;
      o_mem_result_src      <= 1'b0;
      o_mem_reg_destination <= '0;
      o_mem_read_data       <= '0;
      o_mem_alu_result      <= '0;
      o_mem_pc_plus_4       <= '0;
    end else if (clk_en) begin
      if (o_mem_stall) begin
        o_mem_reg_wr     <= 1'b0;
        o_mem_misaligned <= 1'b0;
      end else begin
        o_mem_misaligned      <= trap;
        o_mem_mem_to_reg      <= i_ex_mem_to_reg;
        o_mem_reg_wr          <= i_ex_reg_wr & ~trap;
        o_mem_result_src      <= i_ex_result_src;
        o_mem_reg_destination <= i_ex_reg_destination;
        o_mem_read_data       <= is_load ? load_ext : '0;
        o_mem_alu_result      <= i_ex_alu_result;
        o_mem_pc_plus_4       <= i_ex_pc_plus_4;
      end
    end
  end

endmodule
